cpu_fpu_float: RTL and testbench
================================

Name: cpu_fpu_float

Overview:
Integer-to-single-precision converter for FCVT.S.W and FCVT.S.WU; the inverse of the FPU float-to-int unit. It sits beside the other FPU sub-units and uses the same request/ready handshake toward the FPU dispatcher. It is a multi-cycle iterative state machine: it takes the magnitude, normalizes it, rounds to nearest-even and packs an IEEE-754 binary32 word.

Parameters:
- FAST_NORMALIZE, 0, 0 = shift one bit per cycle in NORMALIZE; 1 = single-cycle normalize using a leading-zero count and barrel shift.

Ports:
- i_clock  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_request  input  1  conversion request; held high until o_ready is seen.
- i_op1  input  32  integer operand.
- i_signed  input  1  1 = treat i_op1 as two's complement (W); 0 = unsigned (WU).
- o_ready  output  1  result valid; held until i_request drops.
- o_result  output  32  binary32 result.

Behaviour:
- Reset (i_reset low, asynchronous):
  - state = IDLE, o_ready = 0, o_result = 0, all internal registers = 0.
  - Applies at any point, including mid-conversion; the partial result is discarded.
- States: IDLE, CHECK, NORMALIZE, ROUND, PUT_Z.
- IDLE:
  - o_ready = 0.
  - On i_request = 1: latch sign s = i_signed & i_op1[31]; mag = s ? -i_op1 : i_op1 (32-bit unsigned; -0x80000000 gives 0x80000000); go to CHECK.
  - i_op1 and i_signed are not sampled after this edge.
- CHECK:
  - If mag == 0: z = 0x00000000 (never -0), go to PUT_Z.
  - Otherwise exp = 158 (127+31), go to NORMALIZE.
- NORMALIZE:
  - FAST_NORMALIZE = 0: while mag[31] == 0, mag <<= 1 and exp -= 1, one bit per cycle. When mag[31] == 1, go to ROUND.
  - FAST_NORMALIZE = 1: mag <<= lzc(mag), exp -= lzc, then go to ROUND. This takes exactly one cycle.
- ROUND:
  - m = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up iff guard & (sticky | m[0]).
  - If m+1 overflows 23 bits: m = 0 and exp += 1.
  - z = {s, exp[7:0], m}; go to PUT_Z.
  - Exponent is at most 159, so overflow to infinity cannot occur.
- PUT_Z:
  - o_result <= z.
  - If i_request = 1: o_ready <= 1 and stay in PUT_Z.
  - If i_request = 0: o_ready <= 0 and go to IDLE.
- Latency, with the edge that samples i_request in IDLE counted as edge 1 and n = leading zeros of mag:
  - Zero input: o_ready high after edge 3.
  - Nonzero input, slow mode: o_ready high after edge n+5, so 5 to 36 edges.
  - Nonzero input, fast mode: o_ready high after edge 5.
- Handshake rules:
  - Dropping i_request mid-conversion does not abort. The unit finishes, updates o_result, never raises o_ready, and returns to IDLE.
  - A new request is accepted only in IDLE, so i_request must be low for at least one cycle after o_ready.
- o_result holds its last value in IDLE; consumers must qualify it with o_ready.
- Undefined state encodings go to IDLE.

Decomposition:
- Shared FPU package (CPU_FPU_Pkg):
  - Constants FLOAT_BIAS = 127 and FLOAT_EXP_W = 8, FLOAT_MANT_W = 23.
  - Typedef float32_t {sign, exp, mant}.
- Local state_t enum stays in the module.
- One natural sub-module: cpu_fpu_lzc32, a 32-bit leading-zero counter, instantiated only when FAST_NORMALIZE = 1.
- Rounding stays inline.

Test Plan:
- i_op1 = 0x00000001, i_signed = 1 -> o_result 0x3F800000. Slow mode: o_ready after edge 36. Fast mode: after edge 5.
- i_op1 = 0xFFFFFFFF: i_signed = 1 -> 0xBF800000 (-1.0); i_signed = 0 -> 0x4F800000 (round-up carry into exponent).
- i_op1 = 0x80000000, i_signed = 1 -> 0xCF000000, o_ready after edge 5. i_op1 = 0x00000000 -> 0x00000000, o_ready after edge 3.
- Ties to even: 0x01000001 -> 0x4B800000 (round down); 0x01000003 -> 0x4B800002 (round up). 0x01000005 with i_signed = 0 -> 0x4B800002 (tie to even, round down).
- Async reset pulsed low mid-NORMALIZE for 0x00000007 -> o_ready = 0, o_result = 0 immediately, without waiting for a clock edge. A fresh request for 7 then gives 0x40E00000.
- i_request dropped during NORMALIZE -> o_ready never rises and the unit returns to IDLE. The next request for 0x0000000A gives 0x41200000, and o_ready stays high until i_request falls, then clears on the next edge.

Source files
------------

// File: rtl/CPU_FPU_Pkg.sv
// Shared FPU definitions: binary32 field widths, exponent bias and the packed float word.
package CPU_FPU_Pkg;

    localparam int FLOAT_BIAS   = 127;
    localparam int FLOAT_EXP_W  = 8;
    localparam int FLOAT_MANT_W = 23;

    typedef struct packed {
        logic                    sign;
        logic [FLOAT_EXP_W-1:0]  exp;
        logic [FLOAT_MANT_W-1:0] mant;
    } float32_t;

endpackage

// File: rtl/cpu_fpu_lzc32.sv
// 32-bit leading-zero counter; purely combinational, returns 32 for an all-zero input.
module cpu_fpu_lzc32 (
    input  logic [31:0] a_i,
    output logic [5:0]  cnt_o
);

    always_comb begin
        cnt_o = 6'd32;
        // Ascending scan so the most significant set bit wins.
        for (int i = 0; i < 32; i++) begin
            if (a_i[i]) begin
                cnt_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/cpu_fpu_float.sv
// FCVT.S.W / FCVT.S.WU: iterative int32/uint32 to binary32 conversion, round-to-nearest-even.
// Request/ready handshake: o_ready is held in PUT_Z until i_request drops.
module cpu_fpu_float
    import CPU_FPU_Pkg::*;
#(
    parameter bit FAST_NORMALIZE = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic [31:0] i_op1,
    input  logic        i_signed,
    output logic        o_ready,
    output logic [31:0] o_result
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        NORMALIZE = 3'd2,
        ROUND     = 3'd3,
        PUT_Z     = 3'd4
    } state_t;

    localparam logic [FLOAT_EXP_W-1:0] EXP_INIT = FLOAT_EXP_W'(FLOAT_BIAS + 31);

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [31:0]            mag_q, mag_d;
    logic [FLOAT_EXP_W-1:0] exp_q, exp_d;
    float32_t               z_q, z_d;
    logic                   ready_q, ready_d;
    logic [31:0]            result_q, result_d;

    logic [5:0]             lzc_cnt;
    logic                   round_up;
    logic [FLOAT_MANT_W:0]  mant_sum;

    generate
        if (FAST_NORMALIZE) begin : g_lzc
            cpu_fpu_lzc32 u_lzc (
                .a_i   (mag_q),
                .cnt_o (lzc_cnt)
            );
        end else begin : g_no_lzc
            assign lzc_cnt = 6'd0;
        end
    endgenerate

    // Guard is the first dropped bit; ties go to the even mantissa.
    assign round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    assign mant_sum = {1'b0, mag_q[30:8]} + {{FLOAT_MANT_W{1'b0}}, round_up};

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        z_d      = z_q;
        ready_d  = ready_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (i_request) begin
                    sign_d  = i_signed & i_op1[31];
                    mag_d   = (i_signed & i_op1[31]) ? (~i_op1 + 32'd1) : i_op1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mag_q == 32'd0) begin
                    z_d     = '0;
                    state_d = PUT_Z;
                end else begin
                    exp_d   = EXP_INIT;
                    state_d = NORMALIZE;
                end
            end
            NORMALIZE: begin
                if (FAST_NORMALIZE) begin
                    mag_d   = mag_q << lzc_cnt;
                    exp_d   = exp_q - {2'b00, lzc_cnt};
                    state_d = ROUND;
                end else if (mag_q[31]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            ROUND: begin
                z_d.sign = sign_q;
                // A carry out of the mantissa leaves it zero and bumps the exponent.
                z_d.exp  = mant_sum[FLOAT_MANT_W] ? exp_q + 8'd1 : exp_q;
                z_d.mant = mant_sum[FLOAT_MANT_W-1:0];
                state_d  = PUT_Z;
            end
            PUT_Z: begin
                result_d = z_q;
                if (i_request) begin
                    ready_d = 1'b1;
                end else begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            z_q      <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            z_q      <= z_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_cpu_fpu_float.sv
// Scoreboard bench: slow and fast normalize variants run side by side on identical stimulus.
module tb_cpu_fpu_float;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_request;
    logic [31:0] i_op1;
    logic        i_signed;
    logic        rdy_s, rdy_f;
    logic [31:0] res_s, res_f;

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    typedef struct {
        logic [31:0] res;
        int          edge_n;
    } exp_t;

    exp_t q_s[$];
    exp_t q_f[$];
    exp_t e_s, e_f;
    logic prev_s = 1'b0;
    logic prev_f = 1'b0;

    cpu_fpu_float #(.FAST_NORMALIZE(1'b0)) u_slow (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_request (i_request),
        .i_op1     (i_op1),
        .i_signed  (i_signed),
        .o_ready   (rdy_s),
        .o_result  (res_s)
    );

    cpu_fpu_float #(.FAST_NORMALIZE(1'b1)) u_fast (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_request (i_request),
        .i_op1     (i_op1),
        .i_signed  (i_signed),
        .o_ready   (rdy_f),
        .o_result  (res_f)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clock) begin
        if (rdy_s && !prev_s) begin
            if (q_s.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL slow_unexpected_ready: got ready=1, expected no ready (no pending request)");
            end else begin
                e_s = q_s.pop_front();
                check("slow_result", res_s, e_s.res);
                check("slow_latency_edge", 32'(edge_n), 32'(e_s.edge_n));
            end
        end
        prev_s <= rdy_s;
    end

    always @(negedge i_clock) begin
        if (rdy_f && !prev_f) begin
            if (q_f.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL fast_unexpected_ready: got ready=1, expected no ready (no pending request)");
            end else begin
                e_f = q_f.pop_front();
                check("fast_result", res_f, e_f.res);
                check("fast_latency_edge", 32'(edge_n), 32'(e_f.edge_n));
            end
        end
        prev_f <= rdy_f;
    end

    task automatic do_conv(input logic [31:0] op, input logic sgn, input logic [31:0] res);
        logic [31:0] mag;
        logic [31:0] tmp;
        int          n;
        int          waited;
        exp_t        es, ef;
        @(negedge i_clock);
        mag = (sgn && op[31]) ? (~op + 32'd1) : op;
        n   = 0;
        tmp = mag;
        while (tmp != 32'd0 && !tmp[31]) begin
            tmp = tmp << 1;
            n++;
        end
        es.res    = res;
        es.edge_n = edge_n + ((mag == 32'd0) ? 3 : n + 5);
        ef.res    = res;
        ef.edge_n = edge_n + ((mag == 32'd0) ? 3 : 5);
        q_s.push_back(es);
        q_f.push_back(ef);
        i_op1     = op;
        i_signed  = sgn;
        i_request = 1'b1;
        @(posedge i_clock);
        #1;
        // Operands must not be resampled after the accepting edge.
        i_op1    = $urandom;
        i_signed = ~sgn;
        waited   = 0;
        while (!(rdy_s && rdy_f) && waited < 80) begin
            @(negedge i_clock);
            waited++;
        end
        if (!(rdy_s && rdy_f)) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout op=%h: got ready slow=%b fast=%b, expected both 1", op, rdy_s, rdy_f);
        end else begin
            repeat (2) begin
                @(negedge i_clock);
                check("slow_ready_held", {31'b0, rdy_s}, 32'd1);
                check("fast_ready_held", {31'b0, rdy_f}, 32'd1);
            end
        end
        i_request = 1'b0;
        @(negedge i_clock);
        check("slow_ready_cleared", {31'b0, rdy_s}, 32'd0);
        check("fast_ready_cleared", {31'b0, rdy_f}, 32'd0);
        check("slow_result_held", res_s, res);
        check("fast_result_held", res_f, res);
        @(negedge i_clock);
    endtask

    localparam int NV = 8;
    logic [31:0] v_op  [NV] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h0000_0000, 32'h0100_0001, 32'h0100_0003, 32'h0100_0005};
    logic        v_sgn [NV] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] v_res [NV] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4F80_0000, 32'hCF00_0000,
                                32'h0000_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};

    initial begin
        logic seen;
        i_reset   = 1'b0;
        i_request = 1'b0;
        i_op1     = '0;
        i_signed  = 1'b0;
        repeat (2) @(negedge i_clock);
        check("slow_reset_ready", {31'b0, rdy_s}, 32'd0);
        check("fast_reset_ready", {31'b0, rdy_f}, 32'd0);
        check("slow_reset_result", res_s, 32'd0);
        check("fast_reset_result", res_f, 32'd0);
        i_reset = 1'b1;
        @(negedge i_clock);

        for (int i = 0; i < NV; i++) begin
            do_conv(v_op[i], v_sgn[i], v_res[i]);
        end

        // Asynchronous reset mid-conversion, asserted away from any clock edge.
        @(negedge i_clock);
        i_op1     = 32'h0000_0007;
        i_signed  = 1'b0;
        i_request = 1'b1;
        repeat (3) @(negedge i_clock);
        #2;
        i_reset = 1'b0;
        #1;
        check("slow_async_reset_ready", {31'b0, rdy_s}, 32'd0);
        check("fast_async_reset_ready", {31'b0, rdy_f}, 32'd0);
        check("slow_async_reset_result", res_s, 32'd0);
        check("fast_async_reset_result", res_f, 32'd0);
        i_request = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        do_conv(32'h0000_0007, 1'b0, 32'h40E0_0000);

        // Request withdrawn during NORMALIZE: unit completes silently.
        @(negedge i_clock);
        i_op1     = 32'h0000_0100;
        i_signed  = 1'b0;
        i_request = 1'b1;
        repeat (2) @(negedge i_clock);
        i_request = 1'b0;
        seen = 1'b0;
        repeat (45) begin
            @(negedge i_clock);
            if (rdy_s || rdy_f) seen = 1'b1;
        end
        check("drop_no_ready", {31'b0, seen}, 32'd0);
        check("slow_drop_result_updated", res_s, 32'h4380_0000);
        check("fast_drop_result_updated", res_f, 32'h4380_0000);
        do_conv(32'h0000_000A, 1'b1, 32'h4120_0000);

        repeat (2) @(negedge i_clock);
        check("slow_scoreboard_drained", 32'(q_s.size()), 32'd0);
        check("fast_scoreboard_drained", 32'(q_f.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
